// File: rtl/optimsoc_functions.sv
// Shared helper package for OpTiMSoC blocks.
// Provides constant functions used to size parameters and registers, plus
// common character constants.
//   clog2_width(value)    : bits needed to index 'value' entries, never below 1
//   decimal_digits(width) : number of decimal digits of 2**width-1
//   ASCII_ZERO            : ASCII code of the character '0'
package optimsoc_functions;

   localparam logic [7:0] ASCII_ZERO = 8'd48;

   // A counter or pointer that covers 'value' entries needs clog2(value)
   // bits, but a zero-width vector is not legal, so one bit is the floor.
   function automatic int clog2_width(input int value);
      int result;
      result = $clog2(value);
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

   // Counts the digits of the largest unsigned value of the given width.
   // Widths of 64 and beyond no longer fit the loop's arithmetic, so they
   // fall back to width*log10(2) in fixed point; 2**width is never a
   // power of ten, which keeps the floor exact.
   function automatic int decimal_digits(input int width);
      int               digits;
      longint unsigned  remaining;
      if (width >= 64) begin
         digits = (width * 30103) / 100000 + 1;
      end else begin
         digits    = 1;
         remaining = (64'd1 << width) - 64'd1;
         while (remaining >= 64'd10) begin
            remaining = remaining / 64'd10;
            digits++;
         end
      end
      return digits;
   endfunction

endpackage

// File: rtl/optimsoc_num2ascii_pkg.sv
// Types and helpers local to the binary-to-ASCII converter.
//   state_e : controller states (IDLE accepts, CONVERT runs double dabble,
//             EMIT streams characters)
//   pow10   : 10**n as a 64-bit constant, used for the digit-count sanity check
package optimsoc_num2ascii_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      EMIT    = 2'd2
   } state_e;

   function automatic longint unsigned pow10(input int n);
      longint unsigned result;
      result = 64'd1;
      for (int i = 0; i < n; i++) begin
         result = result * 64'd10;
      end
      return result;
   endfunction

endpackage

// File: rtl/optimsoc_bcd_step.sv
// One combinational double-dabble step.
// Every BCD nibble that is 5 or more gets 3 added, then the whole BCD
// vector shifts left by one bit with the next binary bit entering at the
// bottom.
//   bcd_i : current BCD register, DIGITS nibbles, least significant first
//   bit_i : next binary bit (MSB of the remaining input value)
//   bcd_o : BCD register after this step
module optimsoc_bcd_step #(
   parameter int DIGITS = 5
) (
   input  logic [4*DIGITS-1:0] bcd_i,
   input  logic                bit_i,
   output logic [4*DIGITS-1:0] bcd_o
);

   logic [4*DIGITS-1:0] corrected;
   logic [3:0]          nibble;

   // Correcting nibbles >= 5 before the shift means that doubling them
   // carries into the next digit exactly like a decimal overflow would.
   always_comb begin
      corrected = bcd_i;
      nibble    = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         nibble = bcd_i[4*i +: 4];
         if (nibble >= 4'd5) begin
            corrected[4*i +: 4] = nibble + 4'd3;
         end
      end
      bcd_o = {corrected[4*DIGITS-2:0], bit_i};
   end

endmodule

// File: rtl/optimsoc_num2ascii.sv
// Streams an unsigned binary number as ASCII decimal characters, most
// significant digit first.
// A number is accepted in IDLE, converted to BCD over WIDTH cycles of
// double dabble, and then emitted one character per out handshake.
//   clk, rst  : clock and synchronous active-high reset
//   in_value  : number to convert, sampled on the accepting edge
//   in_valid  : in_value is valid
//   in_ready  : high in IDLE only
//   out_char  : ASCII '0'..'9'
//   out_valid : high in EMIT only
//   out_ready : downstream accepts out_char
//   out_last  : out_char is the final character of the number
module optimsoc_num2ascii
   import optimsoc_functions::*;
   import optimsoc_num2ascii_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int DIGITS        = optimsoc_functions::decimal_digits(WIDTH),
   parameter bit LEADING_ZEROS = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_value,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_char,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   localparam int CntW = clog2_width(WIDTH);
   localparam int PtrW = clog2_width(DIGITS);
   localparam int BcdW = 4 * DIGITS;

   localparam longint unsigned MaxInput =
      (WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << WIDTH) - 64'd1);

   // Too few digits would silently drop the top of large numbers.
   if (pow10(DIGITS) <= MaxInput) begin : gDigitsTooSmall
      $error("optimsoc_num2ascii: DIGITS cannot hold 2**WIDTH-1");
   end

   state_e          state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [BcdW-1:0] bcd_q, bcd_d, bcdStep;
   logic [CntW-1:0] bitCnt_q, bitCnt_d;
   logic [PtrW-1:0] digitPtr_q, digitPtr_d, msdIndex;
   logic [3:0]      curDigit;

   optimsoc_bcd_step #(
      .DIGITS(DIGITS)
   ) u_bcdStep (
      .bcd_i(bcd_q),
      .bit_i(value_q[WIDTH-1]),
      .bcd_o(bcdStep)
   );

   // Finds the most significant nonzero digit of the BCD value produced
   // by the current step. On the final CONVERT cycle this is the finished
   // result, so the pointer can be loaded without spending an extra scan
   // cycle. An all-zero value leaves index 0, which emits a single '0'.
   always_comb begin
      msdIndex = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (bcdStep[4*i +: 4] != 4'd0) begin
            msdIndex = PtrW'(i);
         end
      end
   end

   // Next-state and datapath update. The bit counter starts at WIDTH-1
   // and CONVERT leaves when it reads zero, giving exactly WIDTH steps.
   always_comb begin
      state_d    = state_q;
      value_d    = value_q;
      bcd_d      = bcd_q;
      bitCnt_d   = bitCnt_q;
      digitPtr_d = digitPtr_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               value_d  = in_value;
               bcd_d    = '0;
               bitCnt_d = CntW'(WIDTH - 1);
               state_d  = CONVERT;
            end
         end
         CONVERT: begin
            value_d = value_q << 1;
            bcd_d   = bcdStep;
            if (bitCnt_q == '0) begin
               state_d    = EMIT;
               digitPtr_d = LEADING_ZEROS ? PtrW'(DIGITS - 1) : msdIndex;
            end else begin
               bitCnt_d = bitCnt_q - CntW'(1);
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (digitPtr_q == '0) begin
                  state_d = IDLE;
               end else begin
                  digitPtr_d = digitPtr_q - PtrW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset clears everything so that the
   // idle output shows '0' and a number in flight is dropped entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         value_q    <= '0;
         bcd_q      <= '0;
         bitCnt_q   <= '0;
         digitPtr_q <= '0;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         bcd_q      <= bcd_d;
         bitCnt_q   <= bitCnt_d;
         digitPtr_q <= digitPtr_d;
      end
   end

   // Outputs depend only on registers, so out_char and out_last cannot
   // move while the consumer stalls.
   always_comb begin
      curDigit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digitPtr_q == PtrW'(i)) begin
            curDigit = bcd_q[4*i +: 4];
         end
      end
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == EMIT);
      out_last  = (state_q == EMIT) && (digitPtr_q == '0);
      out_char  = ASCII_ZERO + {4'd0, curDigit};
   end

endmodule

// File: tb/tb_optimsoc_num2ascii.sv
// Scoreboard bench for optimsoc_num2ascii.
// The driver pushes the expected character string of each accepted number
// (formatted with $sformatf) into a queue; the monitor pops and compares on
// every out handshake, and also watches latency, stall stability and reset.
// A second instance with LEADING_ZEROS=1 checks the zero-padded form.
module tb_optimsoc_num2ascii;

   localparam int WIDTH   = 16;
   localparam int LATENCY = WIDTH + 1;

   typedef struct {
      byte ch;
      bit  last;
   } exp_t;

   typedef struct {
      int cyc;
      bit b2b;
   } acc_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] inValue = '0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [7:0]       outChar;
   logic             outValid;
   logic             outReady;
   logic             outLast;

   logic [WIDTH-1:0] lzInValue = '0;
   logic             lzInValid = 1'b0;
   logic             lzInReady;
   logic [7:0]       lzOutChar;
   logic             lzOutValid;
   logic             lzOutLast;

   logic readyForce  = 1'b1;
   logic randomReady = 1'b0;
   logic rndBit      = 1'b1;
   logic chkIdle     = 1'b0;
   logic chkEnd      = 1'b0;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   lastDoneCyc = 0;

   exp_t expQ[$];
   exp_t lzQ[$];
   acc_t accQ[$];

   assign outReady = randomReady ? rndBit : readyForce;

   optimsoc_num2ascii dut (
      .clk      (clk),
      .rst      (rst),
      .in_value (inValue),
      .in_valid (inValid),
      .in_ready (inReady),
      .out_char (outChar),
      .out_valid(outValid),
      .out_ready(outReady),
      .out_last (outLast)
   );

   optimsoc_num2ascii #(
      .LEADING_ZEROS(1'b1)
   ) dutLz (
      .clk      (clk),
      .rst      (rst),
      .in_value (lzInValue),
      .in_valid (lzInValid),
      .in_ready (lzInReady),
      .out_char (lzOutChar),
      .out_valid(lzOutValid),
      .out_ready(1'b1),
      .out_last (lzOutLast)
   );

   // Free-running clock and cycle index.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Random backpressure source, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      rndBit = 1'($urandom_range(0, 1));
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeoutFail(input string what);
      $display("[TB] FAIL timeout %s: actual=no progress required=progress (cycle %0d)", what, cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] aborting after timeout");
   endtask

   // Reference model: the decimal text of the number, optionally padded
   // to five digits, one queue entry per character.
   task automatic pushExpected(input int unsigned value, input bit pad);
      string s;
      exp_t  e;
      s = pad ? $sformatf("%05d", value) : $sformatf("%0d", value);
      for (int i = 0; i < s.len(); i++) begin
         e.ch   = s[i];
         e.last = (i == s.len() - 1);
         if (pad) lzQ.push_back(e);
         else     expQ.push_back(e);
      end
   endtask

   // Presents a number to the main instance and returns just after the
   // accepting edge, leaving in_valid high for back-to-back use.
   task automatic applyStimulus(input int unsigned value, input bit b2b);
      bit   acc;
      acc_t a;
      inValue = WIDTH'(value);
      inValid = 1'b1;
      for (int n = 0; ; n++) begin
         acc = inReady;
         if (acc) begin
            pushExpected(value, 1'b0);
            a.cyc = cyc;
            a.b2b = b2b;
            accQ.push_back(a);
         end
         @(posedge clk);
         #1;
         if (acc) break;
         if (n > 500) timeoutFail("accept");
      end
   endtask

   task automatic applyLz(input int unsigned value);
      bit acc;
      lzInValue = WIDTH'(value);
      lzInValid = 1'b1;
      for (int n = 0; ; n++) begin
         acc = lzInReady;
         if (acc) pushExpected(value, 1'b1);
         @(posedge clk);
         #1;
         if (acc) break;
         if (n > 500) timeoutFail("accept lz");
      end
      lzInValid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int n = 0; !(expQ.size() == 0 && lzQ.size() == 0 && inReady && lzInReady); n++) begin
         if (n > 2000) timeoutFail("drain");
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: all comparisons happen here, half a cycle away from the
   // active edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      acc_t a;
      logic       prevValid;
      logic       prevReady;
      logic       prevLast;
      logic [7:0] prevChar;
      if (rst) begin
         prevValid = 1'b0;
         prevReady = 1'b0;
         prevLast  = 1'b0;
         prevChar  = 8'd0;
      end else begin
         if (chkIdle) begin
            checkOutput("idle in_ready", inReady, 1);
            checkOutput("idle out_valid", outValid, 0);
            checkOutput("idle out_last", outLast, 0);
            checkOutput("idle out_char", outChar, 48);
         end
         if (chkEnd) begin
            checkOutput("leftover expected chars", expQ.size(), 0);
            checkOutput("leftover padded chars", lzQ.size(), 0);
            checkOutput("leftover accepts", accQ.size(), 0);
         end
         if (prevValid && !prevReady) begin
            checkOutput("stall out_valid", outValid, 1);
            checkOutput("stall out_char", outChar, prevChar);
            checkOutput("stall out_last", outLast, prevLast);
         end
         if (prevValid && prevReady && !prevLast) begin
            checkOutput("consecutive chars", outValid, 1);
         end
         if (outValid && !prevValid) begin
            if (accQ.size() == 0) begin
               checkOutput("accept record present", accQ.size(), 1);
            end else begin
               a = accQ.pop_front();
               checkOutput("first char latency", cyc - a.cyc, LATENCY);
               if (a.b2b) checkOutput("back-to-back accept", a.cyc, lastDoneCyc + 1);
            end
         end
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               checkOutput("expected char present", expQ.size(), 1);
            end else begin
               e = expQ.pop_front();
               checkOutput("out_char", outChar, e.ch);
               checkOutput("out_last", outLast, e.last);
            end
            if (outLast) lastDoneCyc = cyc;
         end
         if (lzOutValid) begin
            if (lzQ.size() == 0) begin
               checkOutput("padded char present", lzQ.size(), 1);
            end else begin
               e = lzQ.pop_front();
               checkOutput("padded out_char", lzOutChar, e.ch);
               checkOutput("padded out_last", lzOutLast, e.last);
            end
         end
         prevValid = outValid;
         prevReady = outReady;
         prevLast  = outLast;
         prevChar  = outChar;
      end
   end

   // Stimulus sequence: directed corner numbers, a mid-number reset,
   // back-to-back numbers, then randomized values and backpressure.
   initial begin
      int unsigned v;
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      chkIdle = 1'b1;
      @(posedge clk);
      #1;
      chkIdle = 1'b0;

      applyStimulus(0, 1'b0);
      inValid = 1'b0;
      waitDrain();
      applyStimulus(65535, 1'b0);
      inValid = 1'b0;
      waitDrain();

      randomReady = 1'b1;
      applyStimulus(1000, 1'b0);
      inValid = 1'b0;
      waitDrain();
      randomReady = 1'b0;

      applyStimulus(12345, 1'b0);
      inValid = 1'b0;
      for (int n = 0; !outValid; n++) begin
         if (n > 100) timeoutFail("first char of 12345");
         @(posedge clk);
         #1;
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      readyForce = 1'b0;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      accQ.delete();
      readyForce = 1'b1;
      chkIdle    = 1'b1;
      @(posedge clk);
      #1;
      chkIdle = 1'b0;
      applyStimulus(7, 1'b0);
      inValid = 1'b0;
      waitDrain();

      applyStimulus(9, 1'b0);
      applyStimulus(10, 1'b1);
      inValid = 1'b0;
      waitDrain();

      randomReady = 1'b1;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 9);
            1:       v = $urandom_range(0, 999);
            2:       v = 65535 - $urandom_range(0, 20);
            default: v = $urandom_range(0, 65535);
         endcase
         applyStimulus(v, 1'b0);
         inValid = 1'b0;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      waitDrain();
      randomReady = 1'b0;

      applyLz(42);
      applyLz(0);
      applyLz(65535);
      for (int k = 0; k < 5; k++) begin
         applyLz($urandom_range(0, 65535));
      end
      waitDrain();

      chkEnd = 1'b1;
      @(posedge clk);
      #1;
      chkEnd = 1'b0;
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/optimsoc_num2ascii.md
OPTIMSOC_NUM2ASCII -- requirements
Module: optimsoc_num2ascii

Interface
REQ-001: Parameter WIDTH, default 16, bit width of the unsigned binary input.
REQ-002: Parameter DIGITS, default optimsoc_functions::decimal_digits(WIDTH), max decimal digits emitted; 5 for WIDTH=16.
REQ-003: Parameter LEADING_ZEROS, default 0; 1 emits all DIGITS characters, 0 suppresses leading zeros.
REQ-004: clk  input  1  sole clock, all state on rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: in_value  input  WIDTH  unsigned number to convert.
REQ-007: in_valid  input  1  in_value is valid.
REQ-008: in_ready  output  1  block accepts a new number.
REQ-009: out_char  output  8  ASCII digit '0'..'9' (8'd48..8'd57).
REQ-010: out_valid  output  1  out_char is valid.
REQ-011: out_ready  input  1  downstream accepts out_char.
REQ-012: out_last  output  1  out_char is the final character of the number.

Function
REQ-013: FSM states SHALL be IDLE, CONVERT, EMIT.
REQ-014: in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in EMIT.
REQ-015: IDLE: on in_valid&&in_ready, capture in_value, clear the BCD register (4*DIGITS bits), load bit counter with WIDTH-1, go to CONVERT.
REQ-016: CONVERT: per cycle, one double-dabble step (add 3 to every BCD nibble >=5, then shift left one bit, taking the binary MSB); after exactly WIDTH cycles go to EMIT.
REQ-017: On CONVERT->EMIT, digit pointer SHALL load the index of the most significant nonzero digit (LEADING_ZEROS=0) or DIGITS-1 (LEADING_ZEROS=1); value 0 with LEADING_ZEROS=0 loads index 0.
REQ-018: Latency: handshake in cycle 0 -> first out_valid in cycle WIDTH+1; no extra cycles for zero suppression.
REQ-019: out_char SHALL equal 8'd48 + BCD nibble at the digit pointer, most significant digit first.
REQ-020: out_char and out_last SHALL remain stable while out_valid && !out_ready.
REQ-021: On out_valid&&out_ready with pointer>0, decrement pointer; with pointer==0 (out_last=1), go to IDLE.
REQ-022: out_last SHALL be 1 iff EMIT and pointer==0.
REQ-023: in_ready SHALL be 1 in the cycle after the last character handshake; no input is accepted during CONVERT or EMIT.
REQ-024: Inputs with in_valid=0 SHALL be ignored; in_value is sampled only on the accepting edge.

Reset
REQ-025: rst SHALL force IDLE, in_ready=1 in the following cycle, out_valid=0, out_last=0, out_char=8'd48, BCD register, bit counter and pointer to 0.
REQ-026: rst during CONVERT or EMIT SHALL abort the number; no further characters of it SHALL appear.
REQ-027: rst SHALL take priority over any simultaneous handshake.

Structure
REQ-028: Function decimal_digits(width) (digits of 2^width-1) and constant ASCII_ZERO=8'd48 SHALL be added to the shared package optimsoc_functions.
REQ-029: Bit counter width SHALL be clog2_width(WIDTH) and pointer width clog2_width(DIGITS), both from optimsoc_functions.
REQ-030: Elaboration SHALL fail if 10**DIGITS <= 2**WIDTH-1.
REQ-031: One combinational sub-module optimsoc_bcd_step (parameter DIGITS; add-3 correction of all nibbles plus one-bit shift) SHALL implement REQ-016.

Verification
REQ-032: in_value=0, out_ready=1 -> one character 8'd48 with out_last=1, first out_valid in cycle 17.
REQ-033: in_value=65535 -> "6","5","5","3","5" on five consecutive cycles, out_last only on the fifth.
REQ-034: LEADING_ZEROS=1, in_value=42 -> "0","0","0","4","2", out_last on "2".
REQ-035: in_value=1000, out_ready toggled 0/1 randomly -> "1000" with out_char/out_last stable throughout each stall.
REQ-036: rst pulsed during EMIT of 12345 after "1","2" -> out_valid=0 next cycle, in_ready=1; following 7 -> only "7".
REQ-037: Back-to-back 9 then 10 with in_valid held -> "9" then "1","0"; second accepted the cycle after "9" handshake.
